// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_cmd_pkg;

  // Frame parser position: waiting for header, then command, argument, checksum.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_CSUM
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;

  // Single-byte shortcuts accepted only while no frame is in progress.
  localparam logic [7:0] LEGACY_INC = 8'h2B;
  localparam logic [7:0] LEGACY_DEC = 8'h2D;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter for a frame in progress.
// Latency: expired is combinational from the count, asserted while count == TIMEOUT_CYC-1.
// Backpressure: none; counts every cycle while enabled and not cleared.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - byte received this cycle; restarts the count
//   en        - a frame is in progress; count held at 0 otherwise
//   expired   - one-cycle pulse when the allowed gap has elapsed with no byte
module uart_rx_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // A byte arriving in the expiry cycle wins, so clr masks the pulse.
  assign expired = en && !clr && (cnt == LAST);

  // Restarting on expiry keeps the pulse to a single cycle even if en lingers.
  always_ff @(posedge clk) begin
    if (rst || clr || !en || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_frame_decoder.sv
// Parses HDR/CMD/ARG/CSUM frames from the UART byte stream into one-hot command pulses.
// Latency: cmd_pulse / frame_err registered, one cycle after the CSUM byte (or timeout expiry).
// Backpressure: none; accepts rx_valid every cycle at full rate.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   rx_valid   - rx_data holds a received byte this cycle
//   rx_data    - received byte
//   cmd_pulse  - one-hot, one-cycle pulse per accepted command
//   cmd_arg    - argument of the last accepted command, held
//   frame_err  - one-cycle pulse per rejected or timed-out frame
//   err_cnt    - rejected frame count, saturating at 8'hFF
// Optional: define UART_CMD_LEGACY_EN to accept the single-byte 2B/2D shortcuts in IDLE.
module uart_cmd_frame_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         NUM_CMD     = 4,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic [NUM_CMD-1:0] cmd_pulse,
  output logic [7:0]         cmd_arg,
  output logic               frame_err,
  output logic [7:0]         err_cnt
);

  state_t     state;
  logic [7:0] cmd_q;
  logic [7:0] arg_q;
  logic [7:0] csum_calc;
  logic       cmd_in_range;
  logic       to_expired;

  // Checksum wraps mod 256 by truncation to 8 bits.
  assign csum_calc    = cmd_q + arg_q;
  assign cmd_in_range = ({24'd0, cmd_q} < 32'(NUM_CMD));

  uart_rx_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid),
    .en     (state != ST_IDLE),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      cmd_pulse <= '0;
      cmd_arg   <= 8'h00;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      cmd_pulse <= '0;
      frame_err <= 1'b0;

      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == HDR_BYTE) begin
              state <= ST_CMD;
            end
`ifdef UART_CMD_LEGACY_EN
            else if (rx_data == LEGACY_INC) begin
              cmd_pulse <= NUM_CMD'(1);
              cmd_arg   <= 8'h01;
            end else if (rx_data == LEGACY_DEC) begin
              cmd_pulse <= NUM_CMD'(2);
              cmd_arg   <= 8'h01;
            end
`endif
          end
          // A header byte here is plain data: no resynchronisation mid-frame.
          ST_CMD: begin
            cmd_q <= rx_data;
            state <= ST_ARG;
          end
          ST_ARG: begin
            arg_q <= rx_data;
            state <= ST_CSUM;
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if ((rx_data == csum_calc) && cmd_in_range) begin
              for (int i = 0; i < NUM_CMD; i++) begin
                cmd_pulse[i] <= (cmd_q == 8'(i));
              end
              cmd_arg <= arg_q;
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (to_expired) begin
        // Partial frame abandoned after too long a gap.
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Bench for uart_cmd_frame_decoder: directed scenarios plus a random byte stream,
// all checked against a queue-based frame model.
module tb_uart_cmd_frame_decoder;

  localparam int         NUM_CMD = 4;
  localparam int         TO      = 20;
  localparam logic [7:0] HDR     = 8'hAA;
`ifdef UART_CMD_LEGACY_EN
  localparam bit LEGACY = 1'b1;
`else
  localparam bit LEGACY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] cmd_pulse;
  logic [7:0] cmd_arg;
  logic       frame_err;
  logic [7:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  uart_cmd_frame_decoder #(
    .NUM_CMD    (NUM_CMD),
    .HDR_BYTE   (HDR),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .cmd_pulse(cmd_pulse),
    .cmd_arg  (cmd_arg),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame collected so far, idle cycles since the last byte.
  logic [7:0] m_buf[$];
  int         m_gap;
  logic [3:0] m_pulse;
  logic [7:0] m_arg;
  logic       m_err;
  logic [7:0] m_cnt;

  task automatic model_reject();
    m_err = 1'b1;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  // Apply one cycle of stimulus {rst, valid, data}; outputs are sampled 1ns after the edge.
  task automatic tick(input logic [9:0] s);
    logic       r;
    logic       v;
    logic [7:0] d;
    int         sum;
    {r, v, d} = s;
    rst = r; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; rx_valid = 1'b0;
    m_pulse = 4'b0000;
    m_err   = 1'b0;
    if (r) begin
      m_buf.delete(); m_gap = 0; m_arg = 8'h00; m_cnt = 8'h00;
    end else if (v) begin
      m_gap = 0;
      if (m_buf.size() == 0) begin
        if (d == HDR) m_buf.push_back(d);
        else if (LEGACY && d == 8'h2B) begin m_pulse = 4'b0001; m_arg = 8'h01; end
        else if (LEGACY && d == 8'h2D) begin m_pulse = 4'b0010; m_arg = 8'h01; end
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == 4) begin
          sum = (int'(m_buf[1]) + int'(m_buf[2])) % 256;
          if (int'(m_buf[3]) == sum && int'(m_buf[1]) < NUM_CMD) begin
            m_pulse = 4'(1 << m_buf[1]);
            m_arg   = m_buf[2];
          end else begin
            model_reject();
          end
          m_buf.delete();
        end
      end
    end else if (m_buf.size() != 0) begin
      m_gap++;
      if (m_gap == TO) begin
        model_reject();
        m_buf.delete();
        m_gap = 0;
      end
    end
  endtask

  function automatic logic [9:0] b(input logic [7:0] d);
    return {2'b01, d};
  endfunction

  localparam logic [9:0] IDLE_CYC = 10'h000;
  localparam logic [9:0] RST_CYC  = 10'h200;

  task automatic test_reset();
    tick(RST_CYC);
    tick(RST_CYC);
    vectors++;
    if ({cmd_pulse, cmd_arg, frame_err, err_cnt} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset: got pulse=%b arg=%h err=%b cnt=%h, want all zero",
               cmd_pulse, cmd_arg, frame_err, err_cnt);
    end
  endtask

  task automatic test_accept();
    logic [9:0] s[$];
    tick(RST_CYC);
    s = '{b(8'hAA), b(8'h01), b(8'h10), b(8'h11)};
    foreach (s[i]) begin
      tick(s[i]);
      vectors++;
      if ({cmd_pulse, cmd_arg, frame_err, err_cnt} !== {m_pulse, m_arg, m_err, m_cnt}) begin
        miscompares++;
        $display("FAIL accept[%0d]: got pulse=%b arg=%h err=%b cnt=%h, want pulse=%b arg=%h err=%b cnt=%h",
                 i, cmd_pulse, cmd_arg, frame_err, err_cnt, m_pulse, m_arg, m_err, m_cnt);
      end
    end
    vectors++;
    if (cmd_pulse !== 4'b0010 || cmd_arg !== 8'h10 || err_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL accept_final: got pulse=%b arg=%h cnt=%h, want pulse=0010 arg=10 cnt=00",
               cmd_pulse, cmd_arg, err_cnt);
    end
    tick(IDLE_CYC);
    vectors++;
    if (cmd_pulse !== 4'b0000 || cmd_arg !== 8'h10) begin
      miscompares++;
      $display("FAIL accept_one_cycle: got pulse=%b arg=%h, want pulse=0000 arg=10", cmd_pulse, cmd_arg);
    end
  endtask

  task automatic test_bad_csum();
    logic [9:0] s[$];
    s = '{b(8'hAA), b(8'h01), b(8'h10), b(8'h12)};
    foreach (s[i]) tick(s[i]);
    vectors++;
    if (frame_err !== 1'b1 || err_cnt !== 8'h01 || cmd_arg !== 8'h10 || cmd_pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL bad_csum: got err=%b cnt=%h arg=%h pulse=%b, want err=1 cnt=01 arg=10 pulse=0000",
               frame_err, err_cnt, cmd_arg, cmd_pulse);
    end
  endtask

  task automatic test_out_of_range();
    logic [9:0] s[$];
    tick(RST_CYC);
    s = '{b(8'hAA), b(8'h07), b(8'h00), b(8'h07)};
    foreach (s[i]) tick(s[i]);
    vectors++;
    if (frame_err !== 1'b1 || err_cnt !== 8'h01 || cmd_pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL out_of_range: got err=%b cnt=%h pulse=%b, want err=1 cnt=01 pulse=0000",
               frame_err, err_cnt, cmd_pulse);
    end
    s = '{b(8'hAA), b(8'h03), b(8'hFF), b(8'h02)};
    foreach (s[i]) tick(s[i]);
    vectors++;
    if (cmd_pulse !== 4'b1000 || cmd_arg !== 8'hFF || frame_err !== 1'b0 || err_cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL csum_wrap: got pulse=%b arg=%h err=%b cnt=%h, want pulse=1000 arg=ff err=0 cnt=01",
               cmd_pulse, cmd_arg, frame_err, err_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] s[$];
    int since;
    int err_at;
    tick(RST_CYC);
    s = '{b(8'hAA), b(8'h02)};
    for (int k = 0; k < 25; k++) s.push_back(IDLE_CYC);
    since = -1;
    err_at = -1;
    foreach (s[i]) begin
      tick(s[i]);
      if (s[i][8]) since = 0;
      else if (since >= 0) since++;
      if (frame_err === 1'b1 && err_at < 0) err_at = since;
      vectors++;
      if ({cmd_pulse, cmd_arg, frame_err, err_cnt} !== {m_pulse, m_arg, m_err, m_cnt}) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got pulse=%b arg=%h err=%b cnt=%h, want pulse=%b arg=%h err=%b cnt=%h",
                 i, cmd_pulse, cmd_arg, frame_err, err_cnt, m_pulse, m_arg, m_err, m_cnt);
      end
    end
    vectors++;
    if (err_at !== 20 || err_cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL timeout_latency: got err after %0d cycles cnt=%h, want 20 cycles cnt=01", err_at, err_cnt);
    end
    // Gap of 19 idle cycles between bytes is the longest that still completes a frame.
    s = '{b(8'hAA), b(8'h02)};
    for (int k = 0; k < TO - 1; k++) s.push_back(IDLE_CYC);
    s.push_back(b(8'h05));
    for (int k = 0; k < TO - 1; k++) s.push_back(IDLE_CYC);
    s.push_back(b(8'h07));
    foreach (s[i]) tick(s[i]);
    vectors++;
    if (cmd_pulse !== 4'b0100 || cmd_arg !== 8'h05 || err_cnt !== 8'h01) begin
      miscompares++;
      $display("FAIL timeout_edge: got pulse=%b arg=%h cnt=%h, want pulse=0100 arg=05 cnt=01",
               cmd_pulse, cmd_arg, err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] s[$];
    logic       seen;
    tick(RST_CYC);
    s = '{b(8'hAA), b(8'h01), RST_CYC, b(8'h10), b(8'h11), IDLE_CYC, IDLE_CYC};
    seen = 1'b0;
    foreach (s[i]) begin
      tick(s[i]);
      if (i >= 2 && (cmd_pulse !== 4'b0000 || frame_err !== 1'b0)) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || err_cnt !== 8'h00 || cmd_arg !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_midframe: got stray_output=%b cnt=%h arg=%h, want 0 00 00", seen, err_cnt, cmd_arg);
    end
  endtask

  task automatic test_saturate();
    logic [9:0] s[$];
    s = '{b(8'hAA), b(8'h01), b(8'h10), b(8'h12)};
    for (int f = 0; f < 300; f++) begin
      foreach (s[i]) tick(s[i]);
      vectors++;
      if ({frame_err, err_cnt} !== {m_err, m_cnt}) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got err=%b cnt=%h, want err=%b cnt=%h", f, frame_err, err_cnt, m_err, m_cnt);
      end
    end
    vectors++;
    if (err_cnt !== 8'hFF) begin
      miscompares++;
      $display("FAIL saturate_final: got cnt=%h, want ff", err_cnt);
    end
  endtask

  task automatic test_legacy();
    logic [3:0] want_p;
    logic [7:0] want_a;
    tick(RST_CYC);
    tick(b(8'h2B));
    want_p = LEGACY ? 4'b0001 : 4'b0000;
    want_a = LEGACY ? 8'h01 : 8'h00;
    vectors++;
    if (cmd_pulse !== want_p || cmd_arg !== want_a || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL legacy_inc: got pulse=%b arg=%h err=%b, want pulse=%b arg=%h err=0",
               cmd_pulse, cmd_arg, frame_err, want_p, want_a);
    end
    tick(b(8'h2D));
    want_p = LEGACY ? 4'b0010 : 4'b0000;
    vectors++;
    if (cmd_pulse !== want_p || cmd_arg !== want_a) begin
      miscompares++;
      $display("FAIL legacy_dec: got pulse=%b arg=%h, want pulse=%b arg=%h", cmd_pulse, cmd_arg, want_p, want_a);
    end
    // Inside a frame 2B is ordinary data, and a header byte in CMD does not resync.
    tick(b(8'hAA)); tick(b(8'h2B));
    vectors++;
    if (cmd_pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL legacy_in_frame: got pulse=%b, want 0000", cmd_pulse);
    end
    tick(b(8'h00)); tick(b(8'h2B));
    vectors++;
    if (frame_err !== 1'b1 || cmd_pulse !== 4'b0000) begin
      miscompares++;
      $display("FAIL legacy_cmd_range: got err=%b pulse=%b, want err=1 pulse=0000", frame_err, cmd_pulse);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [9:0] s[$];
    logic [7:0] c;
    logic [7:0] a;
    int         n;
    tick(RST_CYC);
    for (int it = 0; it < 400; it++) begin
      s.delete();
      c = 8'($urandom_range(0, 3));
      a = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: s = '{b(HDR), b(c), b(a), b(c + a)};
        4:          s = '{b(HDR), b(c), b(a), b(c + a + 8'($urandom_range(1, 255)))};
        5:          s = '{b(HDR), b(8'($urandom_range(4, 255))), b(a), b(8'($urandom))};
        6: begin
          n = $urandom_range(0, 2);
          s.push_back(b(HDR));
          for (int k = 0; k < n; k++) s.push_back(b(8'($urandom)));
        end
        7:          s = '{b(8'($urandom))};
        8:          s = '{b($urandom_range(0, 1) ? 8'h2B : 8'h2D)};
        default:    s = '{b(HDR), b(HDR), b(a), b(HDR + a)};
      endcase
      if ($urandom_range(0, 49) == 0) s.push_back(RST_CYC);
      foreach (s[i]) begin
        n = ($urandom_range(0, 11) == 0) ? $urandom_range(TO - 3, TO + 1) : $urandom_range(0, 1) * $urandom_range(0, 2);
        for (int g = 0; g <= n; g++) begin
          tick(g == n ? s[i] : IDLE_CYC);
          vectors++;
          if ({cmd_pulse, cmd_arg, frame_err, err_cnt} !== {m_pulse, m_arg, m_err, m_cnt}) begin
            miscompares++;
            $display("FAIL random[%0d.%0d]: got pulse=%b arg=%h err=%b cnt=%h, want pulse=%b arg=%h err=%b cnt=%h",
                     it, i, cmd_pulse, cmd_arg, frame_err, err_cnt, m_pulse, m_arg, m_err, m_cnt);
          end
          vectors++;
          if ($countones(cmd_pulse) > 1 || (cmd_pulse != 4'b0000 && frame_err)) begin
            miscompares++;
            $display("FAIL exclusive[%0d.%0d]: got pulse=%b err=%b, want at most one of them", it, i, cmd_pulse, frame_err);
          end
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    m_gap    = 0;
    m_pulse  = 4'b0000;
    m_arg    = 8'h00;
    m_err    = 1'b0;
    m_cnt    = 8'h00;
    test_reset();
    test_accept();
    test_bad_csum();
    test_out_of_range();
    test_timeout();
    test_reset_midframe();
    test_saturate();
    test_legacy();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
